simt_sram: RTL and testbench

SIMT_SRAM -- requirements
Module: simt_sram

---
 rtl/simt_sram.sv | 171 +++++++++++++++++
 tb/tb_simt_sram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/simt_sram.sv
// simt_sram: banked SRAM serving SIMT-style multi-lane requests.
//
// A request carries up to LANES word addresses. Each address maps to one
// of BANKS single-port banks. In each BUSY cycle every bank serves one
// pending lane: the lowest-numbered pending lane that maps to it. A
// request finishes when no lanes remain pending. The block then pulses
// resp_valid for one cycle.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_we             write (1) / read (0), applies to all lanes
//   req_mask           per-lane active bits
//   req_addr           LANES x AW word addresses, lane i at [i*AW +: AW]
//   req_wd             LANES x DW write data, same packing
//   resp_valid         single-cycle completion pulse
//   resp_rd            LANES x DW read data; held until next acceptance
//
// Build option: define SIMT_SRAM_COALESCE_EN to enable read coalescing.
// When it is defined, a read serves every pending lane whose full
// address matches the lane chosen for that bank, in the same cycle.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | serving pending lanes, one per bank per cycle
// RESP  | resp_valid pulse, return to IDLE next cycle

module simt_sram #(
  parameter int LANES = 4,
  parameter int BANKS = 4,
  parameter int AW    = 14,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [LANES-1:0]    req_mask,
  input  logic [LANES*AW-1:0] req_addr,
  input  logic [LANES*DW-1:0] req_wd,
  output logic                resp_valid,
  output logic [LANES*DW-1:0] resp_rd
);

  localparam int BW   = $clog2(BANKS);
  localparam int RW   = AW - BW;
  localparam int ROWS = (1 << AW) / BANKS;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q;
  logic                  we_q;
  logic [LANES*AW-1:0]   addr_q;
  logic [LANES*DW-1:0]   wd_q;
  logic [LANES-1:0]      pend_q;
  logic [LANES-1:0]      pend_d;
  logic [LANES*DW-1:0]   rd_q;
  logic                  resp_valid_q;

  logic [DW-1:0]         mem [BANKS][ROWS];

  logic [AW-1:0]         lane_addr [LANES];
  logic [BW-1:0]         lane_bank [LANES];
  logic [RW-1:0]         lane_row  [LANES];
  logic [DW-1:0]         lane_wd   [LANES];

  logic                  bk_en    [BANKS];
  logic [LW-1:0]         bk_sel   [BANKS];
  logic [RW-1:0]         bk_row   [BANKS];
  logic [DW-1:0]         bk_wd    [BANKS];
  logic [DW-1:0]         bk_rdata [BANKS];

  logic [LANES-1:0]      svc;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = addr_q[i*AW +: AW];
      lane_bank[i] = addr_q[i*AW +: BW];
      lane_row[i]  = addr_q[i*AW+BW +: RW];
      lane_wd[i]   = wd_q[i*DW +: DW];
    end
  end

  // Per-bank arbitration: the lowest-numbered pending lane wins.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bk_en[b]  = 1'b0;
      bk_sel[b] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (!bk_en[b] && pend_q[i] && (lane_bank[i] == BW'(b))) begin
          bk_en[b]  = 1'b1;
          bk_sel[b] = LW'(i);
        end
      end
      bk_row[b]   = lane_row[bk_sel[b]];
      bk_wd[b]    = lane_wd[bk_sel[b]];
      bk_rdata[b] = mem[b][bk_row[b]];
    end
  end

  // A pending lane is served when it won its bank. With coalescing on,
  // a pending read is also served when its address matches the winner's.
  always_comb begin
    svc = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef SIMT_SRAM_COALESCE_EN
      svc[i] = (state_q == BUSY) && pend_q[i] &&
               ((bk_sel[lane_bank[i]] == LW'(i)) ||
                (!we_q && (lane_addr[i] == lane_addr[bk_sel[lane_bank[i]]])));
`else
      svc[i] = (state_q == BUSY) && pend_q[i] && (bk_sel[lane_bank[i]] == LW'(i));
`endif
    end
    pend_d = pend_q & ~svc;
  end

  // Arrays carry no reset. A write stays blocked on an edge where reset
  // is high, so an aborted request loses any write it has not yet served.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (!reset && (state_q == BUSY) && we_q && bk_en[b])
        mem[b][bk_row[b]] <= bk_wd[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      pend_q       <= '0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= BUSY;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wd_q    <= req_wd;
            pend_q  <= req_mask;
            rd_q    <= '0;
          end
        end
        BUSY: begin
          pend_q <= pend_d;
          for (int i = 0; i < LANES; i++) begin
            if (svc[i] && !we_q)
              rd_q[i*DW +: DW] <= bk_rdata[lane_bank[i]];
          end
          if (pend_d == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rd    = rd_q;

endmodule

// File: tb/tb_simt_sram.sv
module tb_simt_sram;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [3:0]   req_mask;
  logic [55:0]  req_addr;
  logic [127:0] req_wd;
  logic         resp_valid;
  logic [127:0] resp_rd;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] DA = 32'hA0A0_0001, DB = 32'hB0B0_0002,
                          DC = 32'hC0C0_0003, DD = 32'hD0D0_0004;
  localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h2222_0001,
                          W2 = 32'h3333_0002, W3 = 32'h4444_0003;
  localparam logic [31:0] N0 = 32'h5A5A_0000, N1 = 32'h5A5A_0001,
                          N2 = 32'h5A5A_0002, N3 = 32'h5A5A_0003;

`ifdef SIMT_SRAM_COALESCE_EN
  localparam int SAME_LAT = 2;
`else
  localparam int SAME_LAT = 5;
`endif

  simt_sram dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_mask(req_mask), .req_addr(req_addr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd(resp_rd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues one request from IDLE and reports its latency in cycles after
  // the accept edge (99 if it never completed), the response data, and
  // whether req_ready stayed low while waiting.
  task automatic issue(input logic we, input logic [3:0] m, input logic [55:0] a,
                       input logic [127:0] d, output int lat, output logic [127:0] rd,
                       output logic rdy_low);
    req_we = we; req_mask = m; req_addr = a; req_wd = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!resp_valid && lat < 20) begin
      if (req_ready) rdy_low = 1'b0;
      step();
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rd;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mask = '0; req_addr = '0; req_wd = '0;
    step(); step();
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready); else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", resp_valid); else pass_cnt++;
    total_cnt++;
    if (resp_rd !== 128'h0) $display("FAIL reset_rd got=%h exp=0", resp_rd); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_conflict_free();
    int lat; logic [127:0] rd; logic rl;
    issue(1'b1, 4'hF, {14'd3, 14'd2, 14'd1, 14'd0}, {DD, DC, DB, DA}, lat, rd, rl);
    total_cnt++;
    if (lat !== 2) $display("FAIL cf_write_lat got=%0d exp=2", lat); else pass_cnt++;
    issue(1'b0, 4'hF, {14'd3, 14'd2, 14'd1, 14'd0}, '0, lat, rd, rl);
    total_cnt++;
    if (lat !== 2) $display("FAIL cf_read_lat got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== {DD, DC, DB, DA}) $display("FAIL cf_read_data got=%h exp=%h", rd, {DD, DC, DB, DA}); else pass_cnt++;
  endtask

  task automatic test_masked();
    int lat; logic [127:0] rd; logic rl;
    issue(1'b0, 4'b0101, {14'd3, 14'd2, 14'd1, 14'd0}, '0, lat, rd, rl);
    total_cnt++;
    if (rd !== {32'h0, DC, 32'h0, DA}) $display("FAIL mask_data got=%h exp=%h", rd, {32'h0, DC, 32'h0, DA}); else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL mask_lat got=%0d exp=2", lat); else pass_cnt++;
    issue(1'b0, 4'b0000, {14'd3, 14'd2, 14'd1, 14'd0}, '0, lat, rd, rl);
    total_cnt++;
    if (lat !== 2) $display("FAIL mask0_lat got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 128'h0) $display("FAIL mask0_data got=%h exp=0", rd); else pass_cnt++;
  endtask

  task automatic test_bank_conflict();
    int lat; logic [127:0] rd; logic rl;
    issue(1'b1, 4'hF, {14'd12, 14'd8, 14'd4, 14'd0}, {W3, W2, W1, W0}, lat, rd, rl);
    total_cnt++;
    if (lat !== 5) $display("FAIL bc_write_lat got=%0d exp=5", lat); else pass_cnt++;
    issue(1'b0, 4'hF, {14'd12, 14'd8, 14'd4, 14'd0}, '0, lat, rd, rl);
    total_cnt++;
    if (lat !== 5) $display("FAIL bc_read_lat got=%0d exp=5", lat); else pass_cnt++;
    total_cnt++;
    if (rl !== 1'b1) $display("FAIL bc_ready_low got=%b exp=1", rl); else pass_cnt++;
    total_cnt++;
    if (rd !== {W3, W2, W1, W0}) $display("FAIL bc_read_data got=%h exp=%h", rd, {W3, W2, W1, W0}); else pass_cnt++;
  endtask

  task automatic test_same_addr();
    int lat; logic [127:0] rd; logic rl;
    issue(1'b1, 4'hF, {14'd7, 14'd7, 14'd7, 14'd7}, {32'd44, 32'd33, 32'd22, 32'd11}, lat, rd, rl);
    total_cnt++;
    if (lat !== 5) $display("FAIL sa_write_lat got=%0d exp=5", lat); else pass_cnt++;
    issue(1'b0, 4'hF, {14'd7, 14'd7, 14'd7, 14'd7}, '0, lat, rd, rl);
    total_cnt++;
    if (rd !== {4{32'd44}}) $display("FAIL sa_write_order got=%h exp=%h", rd, {4{32'd44}}); else pass_cnt++;
    total_cnt++;
    if (lat !== SAME_LAT) $display("FAIL sa_read7_lat got=%0d exp=%0d", lat, SAME_LAT); else pass_cnt++;
    issue(1'b1, 4'b0001, {14'd0, 14'd0, 14'd0, 14'd5}, {96'h0, 32'h0555_5555}, lat, rd, rl);
    issue(1'b0, 4'hF, {14'd5, 14'd5, 14'd5, 14'd5}, '0, lat, rd, rl);
    total_cnt++;
    if (lat !== SAME_LAT) $display("FAIL sa_read5_lat got=%0d exp=%0d", lat, SAME_LAT); else pass_cnt++;
    total_cnt++;
    if (rd !== {4{32'h0555_5555}}) $display("FAIL sa_read5_data got=%h exp=%h", rd, {4{32'h0555_5555}}); else pass_cnt++;
  endtask

  task automatic test_hold();
    int lat; logic [127:0] rd; logic rl;
    issue(1'b0, 4'b0110, {14'd3, 14'd2, 14'd1, 14'd0}, '0, lat, rd, rl);
    step(); step(); step();
    total_cnt++;
    if (resp_rd !== {32'h0, DC, DB, 32'h0}) $display("FAIL hold_data got=%h exp=%h", resp_rd, {32'h0, DC, DB, 32'h0}); else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL hold_pulse got=%b exp=0", resp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] rd; logic rl; logic seen;
    req_we = 1'b1; req_mask = 4'hF; req_addr = {14'd12, 14'd8, 14'd4, 14'd0};
    req_wd = {N3, N2, N1, N0}; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL rm_ready_in_reset got=%b exp=0", req_ready); else pass_cnt++;
    step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rm_ready_after got=%b exp=1", req_ready); else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) seen = 1'b1;
      step();
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rm_no_resp got=%b exp=0", seen); else pass_cnt++;
    issue(1'b0, 4'b1001, {14'd12, 14'd8, 14'd4, 14'd0}, '0, lat, rd, rl);
    total_cnt++;
    if (rd[31:0] !== N0) $display("FAIL rm_addr0 got=%h exp=%h", rd[31:0], N0); else pass_cnt++;
    total_cnt++;
    if (rd[127:96] !== W3) $display("FAIL rm_addr12 got=%h exp=%h", rd[127:96], W3); else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL rm_read_lat got=%0d exp=3", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_conflict_free();
    test_masked();
    test_bank_conflict();
    test_same_addr();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
